// File: rtl/tia_hsync_ctrl_pkg.sv
// Shared horizontal-timing constants and the polynomial counter step.
package tia_hsync_ctrl_pkg;

  localparam int unsigned LFSR_W = 6;
  localparam int unsigned STEP_W = 6;
  localparam logic [LFSR_W-1:0] LFSR_SEED = '0;

  localparam int unsigned DEF_LINE_STEPS  = 57;
  localparam int unsigned DEF_HS_START    = 4;
  localparam int unsigned DEF_HS_END      = 8;
  localparam int unsigned DEF_CB_START    = 9;
  localparam int unsigned DEF_CB_END      = 13;
  localparam int unsigned DEF_HB_END      = 16;
  localparam int unsigned DEF_LATE_HB_END = 18;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_t;

  // Shift right, feeding the XNOR of the two low bits into the top.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {~(v[0] ^ v[1]), v[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/tia_hpoly_counter.sv
// 6-bit polynomial horizontal counter with a parallel step index.
module tia_hpoly_counter
  import tia_hsync_ctrl_pkg::*;
#(
  parameter int unsigned LINE_STEPS = DEF_LINE_STEPS
) (
  input  logic              clk,
  input  logic              rl,
  input  logic              adv,
  input  logic              clr,
  output logic [STEP_W-1:0] step,
  output logic [LFSR_W-1:0] lfsr
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(LINE_STEPS - 1);

  // Force-to-zero wins over advance; the line wraps back to the seed.
  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      step <= '0;
      lfsr <= LFSR_SEED;
    end else if (clr) begin
      step <= '0;
      lfsr <= LFSR_SEED;
    end else if (adv) begin
      if (step == LAST_STEP) begin
        step <= '0;
        lfsr <= LFSR_SEED;
      end else begin
        step <= step + STEP_W'(1);
        lfsr <= lfsr_next(lfsr);
      end
    end
  end

endmodule

// File: rtl/tia_hsync_ctrl.sv
// Horizontal-timing sequencer: phase divider, counter, decodes, late blank, RDY.
module tia_hsync_ctrl
  import tia_hsync_ctrl_pkg::*;
#(
  parameter int unsigned LINE_STEPS  = DEF_LINE_STEPS,
  parameter int unsigned HS_START    = DEF_HS_START,
  parameter int unsigned HS_END      = DEF_HS_END,
  parameter int unsigned CB_START    = DEF_CB_START,
  parameter int unsigned CB_END      = DEF_CB_END,
  parameter int unsigned HB_END      = DEF_HB_END,
  parameter int unsigned LATE_HB_END = DEF_LATE_HB_END
) (
  input  logic              clk,
  input  logic              rl,
  input  logic              rsync,
  input  logic              wsync,
  input  logic              hmove,
  output logic              phi1,
  output logic              phi2,
  output logic [LFSR_W-1:0] hcount,
  output logic              hsync,
  output logic              hblank,
  output logic              cburst,
  output logic              line_start,
  output logic              rdy
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(LINE_STEPS - 1);
  localparam logic [STEP_W-1:0] HS_S      = STEP_W'(HS_START);
  localparam logic [STEP_W-1:0] HS_E      = STEP_W'(HS_END);
  localparam logic [STEP_W-1:0] CB_S      = STEP_W'(CB_START);
  localparam logic [STEP_W-1:0] CB_E      = STEP_W'(CB_END);
  localparam logic [STEP_W-1:0] HB_E      = STEP_W'(HB_END);
  localparam logic [STEP_W-1:0] LHB_E     = STEP_W'(LATE_HB_END);
  localparam logic [STEP_W-1:0] LHB_PRE   = STEP_W'(LATE_HB_END - 1);

  phase_t            phase, phase_nxt;
  logic [STEP_W-1:0] step;
  logic              adv;
  logic              enter_line;
  logic              enter_late_end;
  logic              late;

  // Phase sequence 0-1-2-3-0.
  always_comb begin
    phase_nxt = PH0;
    case (phase)
      PH0: phase_nxt = PH1;
      PH1: phase_nxt = PH2;
      PH2: phase_nxt = PH3;
      PH3: phase_nxt = PH0;
      default: phase_nxt = PH0;
    endcase
  end

  // Phase register; rsync restarts the step at phase 0.
  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      phase <= PH0;
    end else if (rsync) begin
      phase <= PH0;
    end else begin
      phase <= phase_nxt;
    end
  end

  assign adv            = (phase == PH3);
  assign enter_line     = rsync | (adv & (step == LAST_STEP));
  assign enter_late_end = ~rsync & adv & (step == LHB_PRE);

  tia_hpoly_counter #(
    .LINE_STEPS(LINE_STEPS)
  ) u_cnt (
    .clk  (clk),
    .rl   (rl),
    .adv  (adv),
    .clr  (rsync),
    .step (step),
    .lfsr (hcount)
  );

  // Late-blank flag: hmove sets it, entering the late end step clears it.
  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      late <= 1'b0;
    end else if (hmove) begin
      late <= 1'b1;
    end else if (enter_late_end) begin
      late <= 1'b0;
    end
  end

  // CPU ready: wsync stalls, the next line start releases.
  always_ff @(posedge clk or negedge rl) begin
    if (!rl) begin
      rdy <= 1'b1;
    end else if (wsync) begin
      rdy <= 1'b0;
    end else if (enter_line) begin
      rdy <= 1'b1;
    end
  end

  assign phi1       = (phase == PH0);
  assign phi2       = (phase == PH2);
  assign hsync      = (step >= HS_S) && (step < HS_E);
  assign cburst     = (step >= CB_S) && (step < CB_E);
  assign hblank     = (step < HB_E) || (late && (step < LHB_E));
  assign line_start = (step == '0) && (phase == PH0);

endmodule

// File: tb/tb_tia_hsync_ctrl.sv
module tb_tia_hsync_ctrl;

  localparam int unsigned STEPS     = 57;
  localparam int unsigned LINE_CLKS = STEPS * 4;
  localparam int unsigned LATE_END  = 18;

  typedef struct packed {
    logic       phi1;
    logic       phi2;
    logic [5:0] hcount;
    logic       hsync;
    logic       hblank;
    logic       cburst;
    logic       line_start;
    logic       rdy;
  } obs_t;

  localparam obs_t RESET_OBS = '{1'b1, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  logic       clk = 1'b0;
  logic       rl = 1'b1;
  logic       rsync = 1'b0;
  logic       wsync = 1'b0;
  logic       hmove = 1'b0;
  logic       phi1, phi2, hsync, hblank, cburst, line_start, rdy;
  logic [5:0] hcount;

  always #5 clk = ~clk;

  tia_hsync_ctrl #(
    .LINE_STEPS(57),
    .HS_START(4),
    .HS_END(8),
    .CB_START(9),
    .CB_END(13),
    .HB_END(16),
    .LATE_HB_END(18)
  ) dut (
    .clk        (clk),
    .rl         (rl),
    .rsync      (rsync),
    .wsync      (wsync),
    .hmove      (hmove),
    .phi1       (phi1),
    .phi2       (phi2),
    .hcount     (hcount),
    .hsync      (hsync),
    .hblank     (hblank),
    .cburst     (cburst),
    .line_start (line_start),
    .rdy        (rdy)
  );

  obs_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [5:0]  lfsr_tab[STEPS];

  int unsigned t = 0;
  bit          late_m = 1'b0;
  bit          rdy_m = 1'b1;

  function automatic obs_t expect_now();
    obs_t        o;
    int unsigned s, ph;
    s  = t / 4;
    ph = t % 4;
    o.phi1       = (ph == 0);
    o.phi2       = (ph == 2);
    o.hcount     = lfsr_tab[s];
    o.hsync      = (s >= 4) && (s < 8);
    o.cburst     = (s >= 9) && (s < 13);
    o.hblank     = (s < 16) || (late_m && (s < 18));
    o.line_start = (t == 0);
    o.rdy        = rdy_m;
    return o;
  endfunction

  always @(posedge clk or negedge rl) begin
    if (!rl) begin
      t      = 0;
      late_m = 1'b0;
      rdy_m  = 1'b1;
      exp_q.delete();
      exp_q.push_back(expect_now());
    end else begin
      if (rsync) t = 0;
      else       t = (t + 1) % LINE_CLKS;
      if (hmove)                       late_m = 1'b1;
      else if (t == LATE_END * 4)      late_m = 1'b0;
      if (wsync)       rdy_m = 1'b0;
      else if (t == 0) rdy_m = 1'b1;
      exp_q.push_back(expect_now());
    end
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{phi1, phi2, hcount, hsync, hblank, cburst, line_start, rdy};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t got phi1=%b phi2=%b hc=%b hs=%b hb=%b cb=%b ls=%b rdy=%b want phi1=%b phi2=%b hc=%b hs=%b hb=%b cb=%b ls=%b rdy=%b",
                 $time, a.phi1, a.phi2, a.hcount, a.hsync, a.hblank, a.cburst, a.line_start, a.rdy,
                 e.phi1, e.phi2, e.hcount, e.hsync, e.hblank, e.cburst, e.line_start, e.rdy);
      end
    end
  end

  task automatic tick(input logic rs, input logic ws, input logic hm);
    rsync = rs;
    wsync = ws;
    hmove = hm;
    @(posedge clk);
    #1;
    rsync = 1'b0;
    wsync = 1'b0;
    hmove = 1'b0;
  endtask

  task automatic do_reset();
    obs_t a;
    rl = 1'b0;
    #1;
    a = '{phi1, phi2, hcount, hsync, hblank, cburst, line_start, rdy};
    checks++;
    if (a !== RESET_OBS) begin
      errors++;
      $display("FAIL reset state @%0t got phi1=%b phi2=%b hc=%b hs=%b hb=%b cb=%b ls=%b rdy=%b",
               $time, a.phi1, a.phi2, a.hcount, a.hsync, a.hblank, a.cburst, a.line_start, a.rdy);
    end
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    rl = 1'b1;
  endtask

  task automatic run_edges(input int unsigned n, input int unsigned rs_at,
                           input int unsigned ws_a, input int unsigned ws_b,
                           input int unsigned hm_at);
    for (int unsigned e = 1; e <= n; e++)
      tick(e == rs_at, (e == ws_a) || (e == ws_b), e == hm_at);
  endtask

  task automatic wait_hsync_rise(input int unsigned max_edges, input int unsigned want);
    int unsigned rise;
    rise = 0;
    for (int unsigned e = 1; e <= max_edges; e++) begin
      tick(1'b0, 1'b0, 1'b0);
      if ((rise == 0) && (hsync === 1'b1)) rise = e;
    end
    checks++;
    if (rise != want) begin
      errors++;
      if (rise == 0)
        $display("FAIL wait expired @%0t: no hsync rise within %0d edges", $time, max_edges);
      else
        $display("FAIL hsync rise at edge %0d after release, want %0d", rise, want);
    end
  endtask

  initial begin
    lfsr_tab[0] = 6'b000000;
    lfsr_tab[1] = 6'b100000;
    lfsr_tab[2] = 6'b110000;
    lfsr_tab[3] = 6'b111000;
    lfsr_tab[4] = 6'b111100;
    lfsr_tab[5] = 6'b111110;
    lfsr_tab[6] = 6'b011111;
    for (int unsigned i = 7; i < STEPS; i++)
      lfsr_tab[i] = {~(lfsr_tab[i-1][0] ^ lfsr_tab[i-1][1]), lfsr_tab[i-1][5:1]};

    #1;
    do_reset();
    run_edges(470, 0, 100, 228, 0);

    do_reset();
    run_edges(240, 0, 0, 0, 8);
    do_reset();
    run_edges(240, 0, 0, 0, 68);
    do_reset();
    run_edges(320, 0, 0, 0, 100);

    do_reset();
    run_edges(300, 50, 0, 0, 0);

    do_reset();
    run_edges(130, 0, 0, 0, 0);
    do_reset();
    wait_hsync_rise(40, 16);

    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        #2;
        rl = 1'b0;
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        rl = 1'b1;
      end else begin
        tick($urandom_range(0, 149) == 0, $urandom_range(0, 49) == 0,
             $urandom_range(0, 39) == 0);
      end
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
